memory_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the instruction-fetch requester (read-only) and the MEM-stage data requester (read/write). A registered FSM grants one requester at a time, drives the memory port, counts out the access latency and returns a one-cycle completion pulse with read data. The data port has priority. A starvation counter guarantees forward progress for fetch. Sits between instruction_fetch_unit / data-path MEM stage and the shared memory.

---
 rtl/memory_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch (read-only) and data (read/write).
// Optional performance counters are enabled by defining ARBITER_PERF_COUNTER_EN.
module memory_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MEMORY_LATENCY = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    fetch_read_data,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_data,
  output logic                     data_ready,
  output logic [DATA_WIDTH-1:0]    data_read_data,
  output logic                     memory_enable,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic                     grant_fetch,
  output logic                     grant_data,
  output logic                     busy
`ifdef ARBITER_PERF_COUNTER_EN
  ,
  output logic [31:0]              fetch_wait_cycles,
  output logic [31:0]              data_wait_cycles,
  output logic [31:0]              conflict_count
`endif
);

  localparam int LW = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEMORY_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          pick_data;
  logic          pick_fetch;

  // Data wins unless fetch has already waited out STARVE_LIMIT data grants.
  always_comb begin
    pick_data  = data_request && !(fetch_request && (starve_cnt == STARVE_MAX));
    pick_fetch = fetch_request && !pick_data;
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state               <= IDLE;
      lat_cnt             <= '0;
      starve_cnt          <= '0;
      fetch_ready         <= 1'b0;
      data_ready          <= 1'b0;
      fetch_read_data     <= '0;
      data_read_data      <= '0;
      memory_enable       <= 1'b0;
      memory_write_enable <= 1'b0;
      memory_address      <= '0;
      memory_write_data   <= '0;
      grant_fetch         <= 1'b0;
      grant_data          <= 1'b0;
      busy                <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_data) begin
            state               <= BUSY;
            busy                <= 1'b1;
            memory_enable       <= 1'b1;
            memory_write_enable <= data_write;
            memory_address      <= data_address;
            memory_write_data   <= data_write_data;
            grant_data          <= 1'b1;
            lat_cnt             <= LAT_LOAD;
            if (!fetch_request)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + SW'(1);
          end else if (pick_fetch) begin
            state               <= BUSY;
            busy                <= 1'b1;
            memory_enable       <= 1'b1;
            memory_write_enable <= 1'b0;
            memory_address      <= fetch_address;
            memory_write_data   <= '0;
            grant_fetch         <= 1'b1;
            lat_cnt             <= LAT_LOAD;
            starve_cnt          <= '0;
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            state               <= DONE;
            memory_enable       <= 1'b0;
            memory_write_enable <= 1'b0;
            if (grant_fetch) begin
              fetch_ready     <= 1'b1;
              fetch_read_data <= memory_read_data;
            end else begin
              data_ready <= 1'b1;
              if (!memory_write_enable)
                data_read_data <= memory_read_data;
            end
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          fetch_ready <= 1'b0;
          data_ready  <= 1'b0;
          grant_fetch <= 1'b0;
          grant_data  <= 1'b0;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARBITER_PERF_COUNTER_EN
  always_ff @(posedge system_clock) begin
    if (reset) begin
      fetch_wait_cycles <= '0;
      data_wait_cycles  <= '0;
      conflict_count    <= '0;
    end else begin
      if (fetch_request && !grant_fetch)
        fetch_wait_cycles <= fetch_wait_cycles + 32'd1;
      if (data_request && !grant_data)
        data_wait_cycles <= data_wait_cycles + 32'd1;
      if (state == IDLE && fetch_request && data_request)
        conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter with a small behavioural memory model.
module tb_memory_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LAT = 2;
  localparam int SLIM = 4;

  logic          system_clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_request = 1'b0;
  logic [AW-1:0] fetch_address = '0;
  logic          fetch_ready;
  logic [DW-1:0] fetch_read_data;
  logic          data_request = 1'b0;
  logic          data_write = 1'b0;
  logic [AW-1:0] data_address = '0;
  logic [DW-1:0] data_write_data = '0;
  logic          data_ready;
  logic [DW-1:0] data_read_data;
  logic          memory_enable;
  logic          memory_write_enable;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data;
  logic [DW-1:0] memory_read_data;
  logic          grant_fetch;
  logic          grant_data;
  logic          busy;
`ifdef ARBITER_PERF_COUNTER_EN
  logic [31:0]   fetch_wait_cycles;
  logic [31:0]   data_wait_cycles;
  logic [31:0]   conflict_count;
`endif

  memory_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_LATENCY(LAT), .STARVE_LIMIT(SLIM)
  ) dut (
    .system_clock(system_clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_read_data(fetch_read_data),
    .data_request(data_request), .data_write(data_write), .data_address(data_address),
    .data_write_data(data_write_data), .data_ready(data_ready), .data_read_data(data_read_data),
    .memory_enable(memory_enable), .memory_write_enable(memory_write_enable),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data),
    .grant_fetch(grant_fetch), .grant_data(grant_data), .busy(busy)
`ifdef ARBITER_PERF_COUNTER_EN
    , .fetch_wait_cycles(fetch_wait_cycles), .data_wait_cycles(data_wait_cycles),
    .conflict_count(conflict_count)
`endif
  );

  always #5 system_clock = ~system_clock;

  logic [DW-1:0] mem [0:255];
  always @(posedge system_clock)
    if (memory_write_enable) mem[memory_address[9:2]] <= memory_write_data;
  assign memory_read_data = memory_enable ? mem[memory_address[9:2]] : '0;

  typedef struct { bit is_fetch; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] last_data_rd = '0;

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge system_clock) begin
    if (fetch_ready === 1'b1 || data_ready === 1'b1) begin
      exp_t e;
      tests_run++;
      if (fetch_ready && data_ready) begin
        tests_failed++;
        $display("FAIL sb_both_ready: got fetch_ready=1 data_ready=1, required one pulse");
      end else if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_ready: got fetch=%0b data=%0b, required no pulse", fetch_ready, data_ready);
      end else begin
        e = sb.pop_front();
        if (e.is_fetch !== fetch_ready ||
            (e.is_fetch ? fetch_read_data : data_read_data) !== e.data) begin
          tests_failed++;
          $display("FAIL sb_completion: got fetch=%0b data=%h, required fetch=%0b data=%h",
                   fetch_ready, e.is_fetch ? fetch_read_data : data_read_data, e.is_fetch, e.data);
        end
      end
    end
  end

  task automatic push(input bit is_fetch, input logic [DW-1:0] d);
    exp_t e;
    e.is_fetch = is_fetch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_access(input bit is_fetch, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int en_cycles, output int we_cycles,
                           output int ready_edge, output bit addr_ok);
    en_cycles = 0; we_cycles = 0; ready_edge = 0; addr_ok = 1'b1;
    if (is_fetch) begin
      fetch_request = 1'b1; fetch_address = addr;
    end else begin
      data_request = 1'b1; data_write = wr; data_address = addr; data_write_data = wdata;
    end
    for (int e = 1; e <= 20; e++) begin
      @(posedge system_clock); #1;
      if (memory_enable) begin
        en_cycles++;
        if (memory_address !== addr || (wr && memory_write_data !== wdata)) addr_ok = 1'b0;
      end
      if (memory_write_enable) we_cycles++;
      if (is_fetch ? fetch_ready : data_ready) begin
        ready_edge = e;
        break;
      end
    end
    fetch_request = 1'b0; data_request = 1'b0; data_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge system_clock);
    #1;
    tests_run++;
    if ({busy, grant_fetch, grant_data, fetch_ready, data_ready, memory_enable, memory_write_enable} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {busy, grant_fetch, grant_data, fetch_ready, data_ready, memory_enable, memory_write_enable});
    end
    tests_run++;
    if (fetch_read_data !== '0 || data_read_data !== '0 || memory_address !== '0 || memory_write_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h, required all 0",
               fetch_read_data, data_read_data, memory_address, memory_write_data);
    end
    reset = 1'b0;
    @(posedge system_clock); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_fetch_read;
    int en, we, re; bit ok;
    push(1'b1, 32'h2402_0005);
    do_access(1'b1, 1'b0, 32'h0000_0040, '0, en, we, re, ok);
    tests_run++;
    if (re !== LAT + 1) begin
      tests_failed++;
      $display("FAIL fetch_latency: got ready edge %0d, required %0d", re, LAT + 1);
    end
    tests_run++;
    if (en !== LAT || we !== 0 || !ok) begin
      tests_failed++;
      $display("FAIL fetch_port: got en=%0d we=%0d addr_ok=%0b, required en=%0d we=0 addr_ok=1", en, we, ok, LAT);
    end
    repeat (3) @(posedge system_clock);
    #1;
    tests_run++;
    if (fetch_read_data !== 32'h2402_0005 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_hold: got data=%h busy=%b, required 24020005 0", fetch_read_data, busy);
    end
  endtask

  task automatic test_data_read;
    int en, we, re; bit ok;
    push(1'b0, 32'h1234_5678);
    last_data_rd = 32'h1234_5678;
    do_access(1'b0, 1'b0, 32'h0000_0080, '0, en, we, re, ok);
    tests_run++;
    if (re !== LAT + 1 || en !== LAT || we !== 0) begin
      tests_failed++;
      $display("FAIL data_read: got ready_edge=%0d en=%0d we=%0d, required %0d %0d 0", re, en, we, LAT + 1, LAT);
    end
    @(posedge system_clock); #1;
  endtask

  task automatic test_data_write;
    int en, we, re; bit ok;
    push(1'b0, last_data_rd);
    do_access(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, en, we, re, ok);
    tests_run++;
    if (we !== LAT || en !== LAT || !ok) begin
      tests_failed++;
      $display("FAIL write_strobe: got we=%0d en=%0d stable=%0b, required %0d %0d 1", we, en, ok, LAT, LAT);
    end
    tests_run++;
    if (re !== LAT + 1 || data_read_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL write_done: got edge=%0d rd=%h, required %0d 12345678", re, data_read_data, LAT + 1);
    end
    @(posedge system_clock); #1;
    tests_run++;
    if (mem[8'h40] !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_mem: got %h, required deadbeef", mem[8'h40]);
    end
  endtask

  // Both requesters held high; pattern bit i set means grant i must go to fetch.
  task automatic test_starvation(input int n, input logic [7:0] pattern);
    int grants = 0;
    bit prev_busy = busy;
    for (int i = 0; i < n; i++) begin
      push(pattern[i], pattern[i] ? 32'h0BAD_F00D : 32'h3000_0003);
      if (!pattern[i]) last_data_rd = 32'h3000_0003;
    end
    fetch_request = 1'b1; fetch_address = 32'h0000_0200;
    data_request = 1'b1; data_write = 1'b0; data_address = 32'h0000_0300;
    for (int e = 0; e < 100 && grants < n; e++) begin
      @(posedge system_clock); #1;
      if (busy && !prev_busy) begin
        tests_run++;
        if (grant_fetch !== pattern[grants] || grant_data !== !pattern[grants]) begin
          tests_failed++;
          $display("FAIL starve_order_%0d: got gf=%b gd=%b, required gf=%b", grants, grant_fetch, grant_data, pattern[grants]);
        end
        grants++;
      end
      prev_busy = busy;
    end
    fetch_request = 1'b0; data_request = 1'b0;
    tests_run++;
    if (grants !== n) begin
      tests_failed++;
      $display("FAIL starve_timeout: got %0d grants, required %0d", grants, n);
    end
    repeat (LAT + 3) @(posedge system_clock);
    #1;
    tests_run++;
    if (sb.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_drain: got pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_drop_mid_busy;
    int pulses = 0;
    bit stray = 1'b0;
    push(1'b0, 32'h1234_5678);
    last_data_rd = 32'h1234_5678;
    data_request = 1'b1; data_write = 1'b0; data_address = 32'h0000_0080;
    @(posedge system_clock); #1;
    data_request = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge system_clock); #1;
      if (data_ready) pulses++;
      if (pulses > 0 && !data_ready && busy) stray = 1'b1;
    end
    tests_run++;
    if (pulses !== 1 || stray) begin
      tests_failed++;
      $display("FAIL drop_mid_busy: got pulses=%0d stray_grant=%0b, required 1 0", pulses, stray);
    end
  endtask

  task automatic test_reset_mid_write;
    data_request = 1'b1; data_write = 1'b1; data_address = 32'h0000_0104; data_write_data = 32'hCAFE_F00D;
    @(posedge system_clock); #1;
    @(posedge system_clock); #1;
    tests_run++;
    if (busy !== 1'b1 || memory_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_setup: got busy=%b we=%b, required 1 1", busy, memory_write_enable);
    end
    reset = 1'b1; data_request = 1'b0; data_write = 1'b0;
    @(posedge system_clock); #1;
    tests_run++;
    if ({busy, memory_enable, memory_write_enable, fetch_ready, data_ready, grant_data} !== 6'b0) begin
      tests_failed++;
      $display("FAIL abort_state: got %b, required 000000",
               {busy, memory_enable, memory_write_enable, fetch_ready, data_ready, grant_data});
    end
    reset = 1'b0;
    last_data_rd = '0;
  endtask

`ifdef ARBITER_PERF_COUNTER_EN
  task automatic test_perf_counters;
    int readies = 0;
    reset = 1'b1;
    @(posedge system_clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 32'h3000_0003);
    fetch_request = 1'b1; fetch_address = 32'h0000_0200;
    data_request = 1'b1; data_write = 1'b0; data_address = 32'h0000_0300;
    for (int e = 0; e < 40 && readies < 3; e++) begin
      @(posedge system_clock); #1;
      if (data_ready) readies++;
    end
    fetch_request = 1'b0; data_request = 1'b0;
    repeat (2) @(posedge system_clock);
    #1;
    tests_run++;
    if (conflict_count !== 32'd3 || fetch_wait_cycles !== 32'd11 || data_wait_cycles !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_counts: got conflict=%0d fwait=%0d dwait=%0d, required 3 11 3",
               conflict_count, fetch_wait_cycles, data_wait_cycles);
    end
    reset = 1'b1;
    @(posedge system_clock); #1;
    reset = 1'b0;
    tests_run++;
    if (conflict_count !== '0 || fetch_wait_cycles !== '0 || data_wait_cycles !== '0) begin
      tests_failed++;
      $display("FAIL perf_reset: got %0d %0d %0d, required 0 0 0", conflict_count, fetch_wait_cycles, data_wait_cycles);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i)};
    mem[8'h10] = 32'h2402_0005;
    mem[8'h20] = 32'h1234_5678;
    mem[8'h80] = 32'h0BAD_F00D;
    mem[8'hC0] = 32'h3000_0003;
    test_reset();
    test_fetch_read();
    test_data_read();
    test_data_write();
    test_starvation(6, 8'b0001_0000);
    test_drop_mid_busy();
    test_reset_mid_write();
    test_starvation(5, 8'b0001_0000);
`ifdef ARBITER_PERF_COUNTER_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
